// File: rtl/regfile_read_port.sv
// regfile_read_port: handshaked register read with write bypass into a 2-entry in-order output buffer
module regfile_read_port #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rd_valid,
  input  logic [2:0]                     rd_addr,
  output logic                           rd_ready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat,
  input  logic                           we,
  input  logic [2:0]                     wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rdata_valid,
  input  logic                           rdata_ready
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d, sel;
  logic push, pop;
  assign rd_ready    = state_q != TWO;
  assign rdata_valid = state_q != EMPTY;
  assign rdata       = rdata_valid ? head_q : '0;
  assign push        = rd_valid && rd_ready;
  assign pop         = rdata_valid && rdata_ready;
  assign sel         = (we && wr_addr == rd_addr) ? wr_data : reg_flat[rd_addr*DATA_WIDTH +: DATA_WIDTH];
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        head_d  = sel;
      end
      ONE: if (push && pop) head_d = sel;
      else if (push) begin
        state_d = TWO;
        tail_d  = sel;
      end else if (pop) state_d = EMPTY;
      TWO: if (pop) begin
        state_d = ONE;
        head_d  = tail_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
endmodule

// File: tb/tb_regfile_read_port.sv
// tb_regfile_read_port: directed vectors with hand-computed expectations for regfile_read_port
module tb_regfile_read_port;
  logic        clk = 1'b0;
  logic        reset, rd_valid, rd_ready, we, rdata_valid, rdata_ready;
  logic [2:0]  rd_addr, wr_addr;
  logic [31:0] wr_data, rdata;
  logic [31:0] regs [8];
  logic [255:0] reg_flat;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    reg_flat = '0;
    for (int i = 0; i < 8; i++) reg_flat[i*32 +: 32] = regs[i];
  end

  regfile_read_port #(.DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .reg_flat(reg_flat), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 32'h100 + i;
    reset = 1; rd_valid = 1; rd_addr = 3'd0; rdata_ready = 0;
    we = 0; wr_addr = 3'd0; wr_data = '0;
    tick(); tick();
    reset = 0; rd_valid = 0;
    check("rst_valid", {31'd0, rdata_valid}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ready", {31'd0, rd_ready}, 1);
    tick();
    check("rst_no_accept", {31'd0, rdata_valid}, 0);

    regs[3] = 32'h0000_00A5;
    rd_valid = 1; rd_addr = 3'd3; rdata_ready = 1;
    tick();
    rd_valid = 0;
    check("basic_valid", {31'd0, rdata_valid}, 1);
    check("basic_data", rdata, 32'h0000_00A5);
    tick();
    check("basic_popped", {31'd0, rdata_valid}, 0);
    check("basic_zero", rdata, 0);

    regs[5] = 32'h1;
    we = 1; wr_addr = 3'd5; wr_data = 32'hDEAD_BEEF; rd_valid = 1; rd_addr = 3'd5;
    tick();
    we = 0; rd_valid = 0; regs[5] = 32'hDEAD_BEEF;
    check("bypass_hit", rdata, 32'hDEAD_BEEF);
    tick();
    we = 1; wr_addr = 3'd6; wr_data = 32'hCAFE_0006; rd_valid = 1; rd_addr = 3'd7;
    tick();
    we = 0; rd_valid = 0; regs[6] = 32'hCAFE_0006;
    check("bypass_miss", rdata, 32'h107);
    tick();

    rdata_ready = 0; regs[2] = 32'h11;
    rd_valid = 1; rd_addr = 3'd2;
    tick();
    rd_valid = 0; we = 1; wr_addr = 3'd2; wr_data = 32'h22;
    tick();
    we = 0; regs[2] = 32'h22;
    check("snap_data", rdata, 32'h11);
    tick();
    check("snap_hold", rdata, 32'h11);
    check("snap_valid", {31'd0, rdata_valid}, 1);
    rdata_ready = 1;
    tick();
    check("snap_popped", {31'd0, rdata_valid}, 0);

    rdata_ready = 0;
    regs[1] = 32'hAAAA_0001; regs[2] = 32'hAAAA_0002; regs[4] = 32'hAAAA_0004;
    rd_valid = 1; rd_addr = 3'd1;
    tick();
    check("bp_ready1", {31'd0, rd_ready}, 1);
    rd_addr = 3'd2;
    tick();
    check("bp_full", {31'd0, rd_ready}, 0);
    check("bp_head", rdata, 32'hAAAA_0001);
    rd_addr = 3'd4;
    tick();
    check("bp_ignored", {31'd0, rd_ready}, 0);
    tick();
    check("bp_stable", rdata, 32'hAAAA_0001);
    rdata_ready = 1;
    tick();
    check("bp_second", rdata, 32'hAAAA_0002);
    check("bp_ready_back", {31'd0, rd_ready}, 1);
    tick();
    rd_valid = 0;
    check("bp_held_read", rdata, 32'hAAAA_0004);
    check("bp_held_valid", {31'd0, rdata_valid}, 1);
    tick();
    check("bp_drained", {31'd0, rdata_valid}, 0);

    rd_valid = 1; rd_addr = 3'd0;
    tick();
    rd_addr = 3'd6;
    check("tp_0", rdata, 32'h100);
    tick();
    rd_addr = 3'd7;
    check("tp_6", rdata, 32'hCAFE_0006);
    check("tp_ready", {31'd0, rd_ready}, 1);
    tick();
    rd_valid = 0;
    check("tp_7", rdata, 32'h107);
    tick();
    check("tp_empty", {31'd0, rdata_valid}, 0);

    rdata_ready = 0; rd_valid = 1; rd_addr = 3'd1;
    tick();
    rd_addr = 3'd2;
    tick();
    rd_valid = 0;
    check("mid_full", {31'd0, rd_ready}, 0);
    reset = 1;
    tick();
    reset = 0;
    check("mid_valid", {31'd0, rdata_valid}, 0);
    check("mid_ready", {31'd0, rd_ready}, 1);
    check("mid_rdata", rdata, 0);
    rdata_ready = 1;
    tick(); tick();
    check("mid_flushed", {31'd0, rdata_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_read_port.md
# regfile_read_port

Buffered read port for the 8-entry register file, the read-side counterpart of the write-enable decode path. It accepts read requests through a valid/ready handshake and selects one of eight registers, with same-cycle write bypass. Each read is snapshotted into a 2-entry in-order buffer and presented to the consumer through a second valid/ready handshake. It sits between the register file storage and the datapath stage that consumes operands.

## Interface
- DATA_WIDTH, 32: width of each register.
- NUM_REGS, 8: register count, fixed at 8 (3-bit address).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rd_valid  input  1  read request present.
- rd_addr  input  3  register index to read.
- rd_ready  output  1  port can accept a request this cycle.
- reg_flat  input  8*DATA_WIDTH  current register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- we  input  1  write enable of the register file write port in the same cycle.
- wr_addr  input  3  write address.
- wr_data  input  DATA_WIDTH  write data.
- rdata  output  DATA_WIDTH  head-of-buffer read data.
- rdata_valid  output  1  rdata holds an unconsumed result.
- rdata_ready  input  1  consumer takes rdata this cycle.

## Operation
- Accept: rd_valid && rd_ready at a rising edge.
- Selected value on accept:
  - wr_data if we && wr_addr == rd_addr (bypass);
  - else reg_flat slice rd_addr.
- The selected value is captured at accept (snapshot). Later writes to that register never alter a buffered entry.
- Pop: rdata_valid && rdata_ready at a rising edge.
- Buffer states:
  - EMPTY (0 entries);
  - ONE (1 entry);
  - TWO (2 entries, full).
- rd_ready = (state != TWO). rdata_valid = (state != EMPTY). rdata = head entry, or all zeros in EMPTY.
- Transitions:
  - EMPTY: push → ONE; otherwise stay.
  - ONE: push only → TWO; pop only → EMPTY; push+pop → ONE, with the new entry becoming head; neither → stay.
  - TWO: pop → ONE, with the second entry becoming head; no push possible since rd_ready=0.
- Order is strictly FIFO; no entry is ever dropped or duplicated.
- rd_valid while rd_ready=0: ignored, no state change. Requester must hold its request.
- rdata and rdata_valid are stable while rdata_valid && !rdata_ready.
- Reset: state EMPTY, both entries cleared to 0, rdata=0, rdata_valid=0, rd_ready=1 from the first cycle after reset. Requests and pops presented while reset is high are ignored.
- Reset mid-operation flushes all buffered entries without delivering them.

## Timing
- Latency: a request accepted at edge N has rdata_valid=1 in the cycle after edge N, provided the buffer was empty or the previous head pops at edge N.
- Throughput: one read per cycle when rdata_ready is held high, sustained indefinitely in state ONE.
- Backpressure: with rdata_ready low, at most 2 requests are accepted. rd_ready drops the cycle after the second accept.
- rd_ready depends only on state, never combinationally on rdata_ready. rdata and rdata_valid are driven from registers and muxes on state only.
- Bypass is combinational within the accept cycle: the write data and the read snapshot land at the same edge.

## Test plan
- Reset then idle: assert reset 2 cycles with rd_valid=1 → rdata_valid=0, rdata=0, rd_ready=1. No entry accepted during reset.
- Basic read: reg3=0x0000_00A5, rd_addr=3 accepted at edge N, rdata_ready=1 → rdata=0x0000_00A5, rdata_valid=1 in cycle N+1, then rdata_valid=0.
- Bypass: we=1, wr_addr=5, wr_data=0xDEAD_BEEF, old reg5=0x1 in the same cycle as a read of 5 → rdata=0xDEAD_BEEF.
- Snapshot: read reg2=0x11 accepted, rdata_ready=0; write reg2=0x22 next cycle → rdata stays 0x11 until popped.
- Backpressure/full: rdata_ready=0, reads of 1, 2, 4 issued back to back → only 1 and 2 accepted, rd_ready=0. Then rdata_ready=1 → outputs reg1 then reg2 in order, rd_ready returns to 1 after the first pop, and the held read of 4 is accepted.
- Reset mid-operation: buffer in TWO, assert reset → next cycle rdata_valid=0, rd_ready=1, and the flushed entries never appear.
